axi4_lite_slave_mem: RTL and testbench

AXI4_LITE_SLAVE_MEM -- requirements
Module: axi4_lite_slave_mem

---
 rtl/axi4_lite_slave_mem.sv | 235 +++++++++++++++++++++++
 tb/tb_axi4_lite_slave_mem.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave backed by a small word-addressed register memory.
// Write and read channels run as independent FSMs; a read issued alongside a write to the same word sees the new data.
module axi4_lite_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [7:0]            WR_CNT,
    output logic [7:0]            RD_CNT
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WRITE,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_DATA
    } r_state_t;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> (IDX_W + 2)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t              w_state, w_next;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic                  aw_cap_q, w_cap_q;
    logic [1:0]            bresp_q;
    logic [7:0]            wr_cnt_q;
    logic                  awready_c, wready_c, bvalid_c;
    logic                  aw_hs, w_hs, b_hs, mem_we;

    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic [7:0]            rd_cnt_q;
    logic                  arready_c, rvalid_c;
    logic                  ar_hs, r_hs, ar_ok, bypass;

    // Write path
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Ready strobes are gated by reset so they stay low while ARESET is held.
    always_comb begin
        w_next    = w_state;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        bvalid_c  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        b_hs      = 1'b0;
        mem_we    = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_c = !aw_cap_q && !ARESET;
                wready_c  = !w_cap_q && !ARESET;
                aw_hs     = AWVALID && awready_c;
                w_hs      = WVALID && wready_c;
                if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
                    w_next = W_WRITE;
                end
            end
            W_WRITE: begin
                mem_we = addr_ok(aw_addr_q);
                w_next = W_RESP;
            end
            W_RESP: begin
                bvalid_c = 1'b1;
                b_hs     = BREADY;
                if (BREADY) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
            wr_cnt_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= AWADDR;
                aw_cap_q  <= 1'b1;
            end
            if (w_hs) begin
                w_data_q <= WDATA;
                w_cap_q  <= 1'b1;
            end
            if (w_state == W_WRITE) begin
                bresp_q <= addr_ok(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
            end
            if (b_hs) begin
                aw_cap_q <= 1'b0;
                w_cap_q  <= 1'b0;
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[addr_idx(aw_addr_q)] <= w_data_q;
        end
    end

    // Read path
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next    = r_state;
        arready_c = 1'b0;
        rvalid_c  = 1'b0;
        ar_hs     = 1'b0;
        r_hs      = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_c = !ARESET;
                ar_hs     = ARVALID && arready_c;
                if (ar_hs) begin
                    r_next = R_READ;
                end
            end
            R_READ: begin
                r_next = R_DATA;
            end
            R_DATA: begin
                rvalid_c = 1'b1;
                r_hs     = RREADY;
                if (RREADY) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // The memory write lands on the same edge as the read sample, so forward the pending word.
    always_comb begin
        ar_ok  = addr_ok(ar_addr_q);
        bypass = mem_we && ar_ok && (addr_idx(aw_addr_q) == addr_idx(ar_addr_q));
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ar_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rd_cnt_q  <= '0;
        end else begin
            if (ar_hs) begin
                ar_addr_q <= ARADDR;
            end
            if (r_state == R_READ) begin
                if (!ar_ok) begin
                    rdata_q <= '0;
                end else if (bypass) begin
                    rdata_q <= w_data_q;
                end else begin
                    rdata_q <= mem[addr_idx(ar_addr_q)];
                end
                rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (r_hs) begin
                rd_cnt_q <= rd_cnt_q + 8'd1;
            end
        end
    end

    assign AWREADY = awready_c;
    assign WREADY  = wready_c;
    assign BVALID  = bvalid_c;
    assign BRESP   = bresp_q;
    assign WR_CNT  = wr_cnt_q;
    assign ARREADY = arready_c;
    assign RVALID  = rvalid_c;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RD_CNT  = rd_cnt_q;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem: write/read handshakes, latency, error responses,
// back-pressure, write-first bypass, mid-transaction reset and counter wrap.
module tb_axi4_lite_slave_mem;

    logic        ACLK;
    logic        ARESET;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [7:0]  WR_CNT;
    logic [7:0]  RD_CNT;

    int checks   = 0;
    int failures = 0;

    axi4_lite_slave_mem #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH (16)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .AWADDR (AWADDR),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA  (WDATA),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .BRESP  (BRESP),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .ARADDR (ARADDR),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .WR_CNT (WR_CNT),
        .RD_CNT (RD_CNT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // AW and W presented together; BREADY is expected high throughout.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] exp_resp, input logic [7:0] exp_cnt);
        AWADDR  = addr;
        WDATA   = data;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        step();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check({tag, "_bvalid_early"}, 32'(BVALID), 32'd0);
        check({tag, "_awready_busy"}, 32'(AWREADY), 32'd0);
        step();
        check({tag, "_bvalid"}, 32'(BVALID), 32'd1);
        check({tag, "_bresp"}, 32'(BRESP), 32'(exp_resp));
        step();
        check({tag, "_bvalid_done"}, 32'(BVALID), 32'd0);
        check({tag, "_wr_cnt"}, 32'(WR_CNT), 32'(exp_cnt));
    endtask

    // RREADY is expected high throughout.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input logic [7:0] exp_cnt);
        ARADDR  = addr;
        ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        check({tag, "_rvalid_early"}, 32'(RVALID), 32'd0);
        check({tag, "_arready_busy"}, 32'(ARREADY), 32'd0);
        step();
        check({tag, "_rvalid"}, 32'(RVALID), 32'd1);
        check({tag, "_rdata"}, RDATA, exp_data);
        check({tag, "_rresp"}, 32'(RRESP), 32'(exp_resp));
        step();
        check({tag, "_rvalid_done"}, 32'(RVALID), 32'd0);
        check({tag, "_rd_cnt"}, 32'(RD_CNT), 32'(exp_cnt));
    endtask

    task automatic quick_read(input logic [31:0] addr);
        ARADDR  = addr;
        ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        step();
        step();
    endtask

    initial begin
        ARESET  = 1'b1;
        AWADDR  = '0;
        AWVALID = 1'b0;
        WDATA   = '0;
        WVALID  = 1'b0;
        BREADY  = 1'b1;
        ARADDR  = '0;
        ARVALID = 1'b0;
        RREADY  = 1'b1;

        // Reset state
        step();
        step();
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_wready", 32'(WREADY), 32'd0);
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_cnts", {16'd0, WR_CNT, RD_CNT}, 32'd0);
        #3;
        ARESET = 1'b0;
        step();
        check("post_rst_awready", 32'(AWREADY), 32'd1);
        check("post_rst_wready", 32'(WREADY), 32'd1);
        check("post_rst_arready", 32'(ARREADY), 32'd1);

        // Same-cycle AW/W write, then read back
        do_write("wr_4", 32'h4, 32'hDEADBEEF, 2'b00, 8'd1);
        do_read("rd_4", 32'h4, 32'hDEADBEEF, 2'b00, 8'd1);

        // W handshake three cycles ahead of AW
        WDATA  = 32'h12345678;
        WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        check("wfirst_wready_low", 32'(WREADY), 32'd0);
        check("wfirst_awready_high", 32'(AWREADY), 32'd1);
        step();
        step();
        check("wfirst_wready_held", 32'(WREADY), 32'd0);
        check("wfirst_bvalid_wait", 32'(BVALID), 32'd0);
        AWADDR  = 32'h8;
        AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        check("wfirst_bvalid_early", 32'(BVALID), 32'd0);
        step();
        check("wfirst_bvalid", 32'(BVALID), 32'd1);
        check("wfirst_bresp", 32'(BRESP), 32'd0);
        step();
        check("wfirst_wr_cnt", 32'(WR_CNT), 32'd2);
        do_read("rd_8", 32'h8, 32'h12345678, 2'b00, 8'd2);

        // Out-of-range and misaligned addresses
        do_write("wr_40", 32'h40, 32'hFFFFFFFF, 2'b10, 8'd3);
        do_write("wr_6", 32'h6, 32'h11111111, 2'b10, 8'd4);
        do_read("rd_40", 32'h40, 32'h0, 2'b10, 8'd3);
        do_read("rd_4_kept", 32'h4, 32'hDEADBEEF, 2'b00, 8'd4);
        do_read("rd_0_kept", 32'h0, 32'h0, 2'b00, 8'd5);

        // RREADY held low for five R_DATA cycles
        RREADY  = 1'b0;
        ARADDR  = 32'h8;
        ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", 32'(RVALID), 32'd1);
            check("bp_rdata", RDATA, 32'h12345678);
            check("bp_arready", 32'(ARREADY), 32'd0);
            check("bp_rd_cnt", 32'(RD_CNT), 32'd5);
            step();
        end
        RREADY = 1'b1;
        step();
        check("bp_rvalid_done", 32'(RVALID), 32'd0);
        check("bp_rd_cnt_done", 32'(RD_CNT), 32'd6);

        // Write and read of 0xC issued on the same edge
        AWADDR  = 32'hC;
        WDATA   = 32'hA5A5A5A5;
        ARADDR  = 32'hC;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        ARVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        step();
        check("byp_bvalid", 32'(BVALID), 32'd1);
        check("byp_rvalid", 32'(RVALID), 32'd1);
        check("byp_rdata", RDATA, 32'hA5A5A5A5);
        check("byp_rresp", 32'(RRESP), 32'd0);
        step();
        check("byp_wr_cnt", 32'(WR_CNT), 32'd5);
        check("byp_rd_cnt", 32'(RD_CNT), 32'd7);
        do_read("rd_c", 32'hC, 32'hA5A5A5A5, 2'b00, 8'd8);

        // Reset while BVALID is pending
        BREADY  = 1'b0;
        AWADDR  = 32'h0;
        WDATA   = 32'h1;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        step();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        step();
        check("abort_bvalid_pre", 32'(BVALID), 32'd1);
        ARESET = 1'b1;
        #1;
        check("abort_bvalid", 32'(BVALID), 32'd0);
        check("abort_wr_cnt", 32'(WR_CNT), 32'd0);
        check("abort_rd_cnt", 32'(RD_CNT), 32'd0);
        check("abort_rdata", RDATA, 32'd0);
        check("abort_awready", 32'(AWREADY), 32'd0);
        step();
        #3;
        ARESET = 1'b0;
        BREADY = 1'b1;
        step();
        do_read("rd_0_after_rst", 32'h0, 32'h0, 2'b00, 8'd1);

        // Read counter wrap
        for (int i = 0; i < 254; i++) begin
            quick_read(32'h0);
        end
        check("wrap_rd_cnt_255", 32'(RD_CNT), 32'd255);
        quick_read(32'h0);
        check("wrap_rd_cnt_0", 32'(RD_CNT), 32'd0);
        check("wrap_wr_cnt", 32'(WR_CNT), 32'd0);
        check("wrap_rvalid", 32'(RVALID), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
